seg_scan_display: RTL and testbench
===================================

# seg_scan_display

Time-multiplexed N-digit seven-segment display driver, the parametrised successor to the single-digit hex segment decoder. It holds a double-buffered frame of hex nibbles with per-digit decimal-point and blank flags, scans one digit at a time at a programmable rate with an anti-ghosting guard interval, and drives shared active-low segment lines plus per-digit active-low anode enables. It sits between the controller's status/debug registers and the board's multiplexed display pins.

## Interface
- N_DIGITS, 8: number of digits scanned; ≥1.
- REFRESH_DIV, 100000: clock cycles per digit slot; ≥ GUARD+2.
- GUARD, 4: cycles at the start of each slot with all anodes off; ≥0.
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- val_i  in  4·N_DIGITS  hex nibbles; digit k is val_i[4k+3:4k], digit 0 rightmost.
- dp_i  in  N_DIGITS  decimal-point request per digit, 1 = lit.
- blank_i  in  N_DIGITS  per-digit blank, 1 = digit dark.
- load_i  in  1  single-cycle strobe; captures val_i/dp_i/blank_i into the shadow buffer.
- pend_o  out  1  shadow buffer holds a frame not yet committed.
- frame_o  out  1  one-cycle pulse at each frame wrap.
- seg_o  out  8  segments {a,b,c,d,e,f,g,dp}, bit7 = a, bit0 = dp, active-low.
- an_o  out  N_DIGITS  anode enables, active-low, at most one low.

## Operation
- Segment encoding (active-low, dp bit = 1): 0→03, 1→9F, 2→25, 3→0D, 4→99, 5→49, 6→41, 7→1F, 8→01, 9→09, A→11, b→C1, C→63, d→85, E→61, F→71 (hex). When dp is lit, clear bit0.
- State: slot counter cnt (0..REFRESH_DIV−1), digit index idx (0..N_DIGITS−1), active buffer, shadow buffer, pend flag.
- Every cycle, cnt increments. At REFRESH_DIV−1 it wraps to 0 and idx advances. idx wraps from N_DIGITS−1 to 0.
- Frame wrap is the cycle where cnt = REFRESH_DIV−1 and idx = N_DIGITS−1. On that cycle:
  - frame_o is 1.
  - If pend = 1, active ← shadow and pend clears.
- load_i = 1: shadow ← inputs, pend ← 1. A repeated load before the commit overwrites the shadow (last one wins).
- Load on the same cycle as the wrap: the old shadow commits, the new data goes into the shadow, and pend stays 1.
- Slot output selection:
  - cnt < GUARD: an_o all ones, seg_o = FF.
  - Otherwise: an_o has only bit idx low; seg_o is the decoded active digit idx with its dp applied.
  - If blank[idx] = 1, seg_o = FF and the anode is still driven.
- Reset (rst_n = 0 at a clk edge):
  - cnt = 0, idx = 0, both buffers cleared (nibbles 0, dp 0, blank all 1s), pend = 0.
  - seg_o = FF, an_o all ones, frame_o = 0, pend_o = 0.
- Reset asserted mid-frame aborts the scan immediately; any pending load is lost.

## Timing
- seg_o, an_o and frame_o are registered: they reflect the cnt/idx/active state of the previous cycle (1-cycle latency).
- pend_o is a direct register output.
- load_i to commit: worst case N_DIGITS·REFRESH_DIV cycles, best case 1 cycle (load immediately before the wrap cycle).
- After a commit, the new data first appears on seg_o at digit 0, slot cycle GUARD, i.e. GUARD+1 cycles after the wrap edge.
- Digit period is REFRESH_DIV cycles; frame period is N_DIGITS·REFRESH_DIV cycles.
- Dark time per slot is exactly GUARD cycles.
- REFRESH_DIV width is clog2(REFRESH_DIV); cnt never exceeds REFRESH_DIV−1.

## Configuration
- SEG_LZB_EN defined: leading-zero blanking.
  - Any digit k above the highest nonzero nibble of the active buffer is forced blank.
  - Digit 0 is never forced blank.
  - Forced blanking ORs with blank_i.
  - Evaluated from the active buffer only.
- SEG_LZB_EN undefined: no logic is generated and only blank_i controls blanking.

## Test plan
Bench parameters: N_DIGITS = 4, REFRESH_DIV = 8, GUARD = 2.
- Reset then idle:
  - seg_o = FF and an_o = F for all cycles, because all digits are blank after reset.
  - frame_o pulses every 32 cycles.
  - pend_o = 0.
- Load val_i = 16'h12AF, dp_i = 4'b0010, blank_i = 0:
  - pend_o = 1 until the wrap.
  - Next frame: digit 0 gives an_o = E, seg_o = 71.
  - Digit 1 gives an_o = D, seg_o = 10 (A with dp).
  - Digits 2/3 give 25/9F.
  - Each slot starts with 2 cycles of an_o = F, seg_o = FF.
- Load on the wrap cycle:
  - First load 1111, second load 2222 exactly on the wrap.
  - The frame shows 1111 with pend_o still 1.
  - The next frame shows 2222, and pend_o then clears.
- blank_i = 4'b0100 with val 16'h8888: digit 2 slot has an_o = B, seg_o = FF; the other digits show 01.
- SEG_LZB_EN defined:
  - val 16'h0030: digits 3 and 2 give seg_o = FF; digit 1 gives 0D; digit 0 gives 03.
  - val 16'h0000: only digit 0 shows 03.
- rst_n low for 1 cycle mid-slot of digit 2:
  - Outputs next cycle are FF / F.
  - The scan restarts at digit 0, cnt = 0, with the display blank.

Source files
------------

// File: rtl/seg_scan_display.sv
// Time-multiplexed N-digit seven-segment driver with double-buffered frame and guard interval.
// Optional leading-zero blanking is enabled by defining SEG_LZB_EN.
module seg_scan_display #(
  parameter int N_DIGITS    = 8,
  parameter int REFRESH_DIV = 100000,
  parameter int GUARD       = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [4*N_DIGITS-1:0]   val_i,
  input  logic [N_DIGITS-1:0]     dp_i,
  input  logic [N_DIGITS-1:0]     blank_i,
  input  logic                    load_i,
  output logic                    pend_o,
  output logic                    frame_o,
  output logic [7:0]              seg_o,
  output logic [N_DIGITS-1:0]     an_o
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int IW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CW-1:0] LAST_CNT  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] GUARD_CNT = CW'(GUARD);
  localparam logic [IW-1:0] LAST_IDX  = IW'(N_DIGITS - 1);

  logic [CW-1:0]           r_cnt;
  logic [IW-1:0]           r_idx;
  logic [4*N_DIGITS-1:0]   r_act_val, r_sh_val;
  logic [N_DIGITS-1:0]     r_act_dp, r_sh_dp;
  logic [N_DIGITS-1:0]     r_act_bl, r_sh_bl;
  logic                    r_pend;
  logic                    r_frame;
  logic [7:0]              r_seg;
  logic [N_DIGITS-1:0]     r_an;

  logic                    w_slot_end;
  logic                    w_wrap;
  logic                    w_in_guard;
  logic [N_DIGITS-1:0]     w_lzb;
  logic [3:0]              w_nib;
  logic                    w_dp;
  logic                    w_bl;
  logic [7:0]              w_seg_nxt;
  logic [N_DIGITS-1:0]     w_an_nxt;

  function automatic logic [7:0] f_seg(input logic [3:0] nib);
    case (nib)
      4'h0: f_seg = 8'h03;  4'h1: f_seg = 8'h9F;  4'h2: f_seg = 8'h25;  4'h3: f_seg = 8'h0D;
      4'h4: f_seg = 8'h99;  4'h5: f_seg = 8'h49;  4'h6: f_seg = 8'h41;  4'h7: f_seg = 8'h1F;
      4'h8: f_seg = 8'h01;  4'h9: f_seg = 8'h09;  4'hA: f_seg = 8'h11;  4'hB: f_seg = 8'hC1;
      4'hC: f_seg = 8'h63;  4'hD: f_seg = 8'h85;  4'hE: f_seg = 8'h61;  default: f_seg = 8'h71;
    endcase
  endfunction

  assign w_slot_end = (r_cnt == LAST_CNT);
  assign w_wrap     = w_slot_end && (r_idx == LAST_IDX);

  generate
    if (GUARD == 0) begin : g_no_guard
      assign w_in_guard = 1'b0;
    end else begin : g_guard
      assign w_in_guard = (r_cnt < GUARD_CNT);
    end
  endgenerate

`ifdef SEG_LZB_EN
  // A digit is dark when it and every digit above it hold zero; digit 0 always shows.
  always_comb begin
    logic v_seen;
    v_seen = 1'b0;
    w_lzb  = '0;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      if (r_act_val[4*k +: 4] != 4'h0) v_seen = 1'b1;
      w_lzb[k] = ~v_seen;
    end
  end
`else
  assign w_lzb = '0;
`endif

  always_comb begin
    w_nib     = 4'h0;
    w_dp      = 1'b0;
    w_bl      = 1'b1;
    w_an_nxt  = '1;
    w_seg_nxt = 8'hFF;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (r_idx == IW'(k)) begin
        w_nib = r_act_val[4*k +: 4];
        w_dp  = r_act_dp[k];
        w_bl  = r_act_bl[k] | w_lzb[k];
      end
    end
    if (!w_in_guard) begin
      for (int k = 0; k < N_DIGITS; k++) begin
        if (r_idx == IW'(k)) w_an_nxt[k] = 1'b0;
      end
      if (!w_bl) w_seg_nxt = f_seg(w_nib) & {7'h7F, ~w_dp};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_idx     <= '0;
      r_act_val <= '0;
      r_act_dp  <= '0;
      r_act_bl  <= '1;
      r_sh_val  <= '0;
      r_sh_dp   <= '0;
      r_sh_bl   <= '1;
      r_pend    <= 1'b0;
      r_frame   <= 1'b0;
      r_seg     <= 8'hFF;
      r_an      <= '1;
    end else begin
      if (w_slot_end) begin
        r_cnt <= '0;
        r_idx <= (r_idx == LAST_IDX) ? '0 : r_idx + 1'b1;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      r_frame <= w_wrap;
      r_seg   <= w_seg_nxt;
      r_an    <= w_an_nxt;
      // Commit reads the old shadow, so a load on the wrap cycle stays pending.
      if (w_wrap && r_pend) begin
        r_act_val <= r_sh_val;
        r_act_dp  <= r_sh_dp;
        r_act_bl  <= r_sh_bl;
      end
      if (load_i) begin
        r_sh_val <= val_i;
        r_sh_dp  <= dp_i;
        r_sh_bl  <= blank_i;
        r_pend   <= 1'b1;
      end else if (w_wrap) begin
        r_pend <= 1'b0;
      end
    end
  end

  assign pend_o  = r_pend;
  assign frame_o = r_frame;
  assign seg_o   = r_seg;
  assign an_o    = r_an;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: randomized and directed frames checked against a cycle-indexed
// reference model through an expected-output queue. Define SEG_LZB_EN for both bench and RTL.
module tb_seg_scan_display;
  localparam int N  = 4;
  localparam int R  = 8;
  localparam int G  = 2;
  localparam int FP = N * R;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [4*N-1:0] val_i;
  logic [N-1:0]   dp_i;
  logic [N-1:0]   blank_i;
  logic           load_i;
  logic           pend_o;
  logic           frame_o;
  logic [7:0]     seg_o;
  logic [N-1:0]   an_o;

  seg_scan_display #(.N_DIGITS(N), .REFRESH_DIV(R), .GUARD(G)) dut (
    .clk(clk), .rst_n(rst_n), .val_i(val_i), .dp_i(dp_i), .blank_i(blank_i),
    .load_i(load_i), .pend_o(pend_o), .frame_o(frame_o), .seg_o(seg_o), .an_o(an_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0]   seg;
    logic [N-1:0] an;
    logic         frame;
    logic         pend;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;
  int   m_t   = 0;

  logic [7:0] seg_tab [16] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99, 8'h49, 8'h41, 8'h1F,
                               8'h01, 8'h09, 8'h11, 8'hC1, 8'h63, 8'h85, 8'h61, 8'h71};

  // Reference model: slot position comes from the cycle count since reset.
  initial begin
    logic [3:0] a_val [N];
    logic [3:0] s_val [N];
    bit         a_dp [N], a_bl [N], s_dp [N], s_bl [N];
    bit         pend;
    int         cyc, cnt, idx, hi;
    bit         wrap, dark;
    exp_t       e;
    for (int k = 0; k < N; k++) begin
      a_val[k] = 0; s_val[k] = 0; a_dp[k] = 0; s_dp[k] = 0; a_bl[k] = 1; s_bl[k] = 1;
    end
    pend = 0;
    forever begin
      @(posedge clk);
      if (rst_n !== 1'b1) begin
        for (int k = 0; k < N; k++) begin
          a_val[k] = 0; s_val[k] = 0; a_dp[k] = 0; s_dp[k] = 0; a_bl[k] = 1; s_bl[k] = 1;
        end
        pend = 0;
        m_t  = 0;
        e = '{seg: 8'hFF, an: '1, frame: 1'b0, pend: 1'b0};
      end else begin
        cyc  = m_t % FP;
        cnt  = cyc % R;
        idx  = cyc / R;
        wrap = (cyc == FP - 1);
        e.seg   = 8'hFF;
        e.an    = '1;
        e.frame = wrap;
        if (cnt >= G) begin
          e.an[idx] = 1'b0;
          hi = -1;
          for (int k = 0; k < N; k++) if (a_val[k] != 0) hi = k;
          dark = a_bl[idx];
`ifdef SEG_LZB_EN
          if (idx > hi && idx != 0) dark = 1;
`endif
          if (!dark) begin
            e.seg = seg_tab[a_val[idx]];
            if (a_dp[idx]) e.seg[0] = 1'b0;
          end
        end
        if (wrap && pend) begin
          a_val = s_val; a_dp = s_dp; a_bl = s_bl;
          pend = 0;
        end
        if (load_i) begin
          for (int k = 0; k < N; k++) begin
            s_val[k] = val_i[4*k +: 4];
            s_dp[k]  = dp_i[k];
            s_bl[k]  = blank_i[k];
          end
          pend = 1;
        end
        e.pend = pend;
        m_t++;
      end
      q.push_back(e);
    end
  end

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        n_cmp++;
        if ({seg_o, an_o, frame_o, pend_o} !== e) begin
          n_err++;
          $display("FAIL out t=%0t got seg=%h an=%h frame=%b pend=%b want seg=%h an=%h frame=%b pend=%b",
                   $time, seg_o, an_o, frame_o, pend_o, e.seg, e.an, e.frame, e.pend);
        end
      end
    end
  end

  task automatic do_load(input logic [4*N-1:0] v, input logic [N-1:0] d, input logic [N-1:0] b);
    val_i = v; dp_i = d; blank_i = b; load_i = 1'b1;
    @(negedge clk);
    load_i = 1'b0;
  endtask

  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while ((m_t % FP) != ph && n < 2 * FP) begin
      @(negedge clk);
      n++;
    end
    if ((m_t % FP) != ph) begin
      n_cmp++;
      n_err++;
      $display("FAIL phase_wait got=%0d want=%0d", m_t % FP, ph);
    end
  endtask

  initial begin
    rst_n = 1'b0; val_i = '0; dp_i = '0; blank_i = '0; load_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    do_load(16'h12AF, 4'b0010, 4'b0000);
    repeat (2 * FP + 3) @(negedge clk);

    do_load(16'h1111, 4'b0000, 4'b0000);
    wait_phase(FP - 1);
    do_load(16'h2222, 4'b0000, 4'b0000);
    repeat (2 * FP + 2) @(negedge clk);

    do_load(16'h8888, 4'b0000, 4'b0100);
    repeat (2 * FP) @(negedge clk);

    do_load(16'h0030, 4'b0000, 4'b0000);
    repeat (2 * FP) @(negedge clk);
    do_load(16'h0000, 4'b0000, 4'b0000);
    repeat (2 * FP) @(negedge clk);

    for (int i = 0; i < 25; i++) begin
      do_load(16'($urandom), 4'($urandom_range(0, 15)),
              ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000);
      repeat ($urandom_range(0, 45)) @(negedge clk);
    end
    repeat (2 * FP) @(negedge clk);

    do_load(16'h5A5A, 4'b1001, 4'b0000);
    repeat (2 * FP) @(negedge clk);
    wait_phase(2 * R + 3);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (FP + 8) @(negedge clk);

    #1;
    n_cmp++;
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL queue_drain got=%0d want=0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
